// File: rtl/amax10_qsys_sensor_int_filter.sv
// Sensor interrupt conditioner: synchronizes and debounces the active-low sensor pin,
// drives a clean level into the PIO and counts qualified asserts; Avalon-MM configured.
module amax10_qsys_sensor_int_filter #(
    parameter int CNT_WIDTH      = 16,
    parameter int DEFAULT_THRESH = 500,
    parameter int SYNC_STAGES    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    input  logic        sensor_int_n,
    output logic        int_out
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        QUAL_LO  = 2'd1,
        ASSERTED = 2'd2,
        QUAL_HI  = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] sync_ff;
    logic                   sync;
    state_t                 state;
    logic                   fsm_level;
    logic [CNT_WIDTH-1:0]   deb_cnt;
    logic [CNT_WIDTH-1:0]   thresh;
    logic [CNT_WIDTH-1:0]   event_cnt;
    logic                   enable;
    logic                   force_lo;

    logic                   wr;
    logic [CNT_WIDTH-1:0]   n_eff;
    logic [CNT_WIDTH:0]     deb_next;
    logic                   reached;
    logic                   n_is_one;
    logic                   qualify;
    logic                   unused_wdata;

    assign wr           = chipselect & ~write_n;
    assign unused_wdata = ^writedata[31:CNT_WIDTH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) sync_ff <= '1;
        else       sync_ff <= {sync_ff[SYNC_STAGES-2:0], sensor_int_n};
    end
    assign sync = sync_ff[SYNC_STAGES-1];

    // A threshold of 0 behaves as 1; compare one bit wider so an all-ones count cannot wrap.
    assign n_eff    = (thresh == '0) ? CNT_WIDTH'(1) : thresh;
    assign n_is_one = (n_eff == CNT_WIDTH'(1));
    assign deb_next = {1'b0, deb_cnt} + 1'b1;
    assign reached  = (deb_next >= {1'b0, n_eff});

    assign qualify = enable && !sync &&
                     (((state == IDLE) && n_is_one) || ((state == QUAL_LO) && reached));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            deb_cnt   <= '0;
            fsm_level <= 1'b1;
        end else if (!enable) begin
            state     <= IDLE;
            deb_cnt   <= '0;
            fsm_level <= 1'b1;
        end else begin
            case (state)
                IDLE: if (!sync) begin
                    if (n_is_one) begin
                        state     <= ASSERTED;
                        deb_cnt   <= '0;
                        fsm_level <= 1'b0;
                    end else begin
                        state   <= QUAL_LO;
                        deb_cnt <= CNT_WIDTH'(1);
                    end
                end
                QUAL_LO: if (sync) begin
                    state   <= IDLE;
                    deb_cnt <= '0;
                end else if (reached) begin
                    state     <= ASSERTED;
                    deb_cnt   <= '0;
                    fsm_level <= 1'b0;
                end else begin
                    deb_cnt <= deb_next[CNT_WIDTH-1:0];
                end
                ASSERTED: if (sync) begin
                    if (n_is_one) begin
                        state     <= IDLE;
                        deb_cnt   <= '0;
                        fsm_level <= 1'b1;
                    end else begin
                        state   <= QUAL_HI;
                        deb_cnt <= CNT_WIDTH'(1);
                    end
                end
                QUAL_HI: if (!sync) begin
                    state   <= ASSERTED;
                    deb_cnt <= '0;
                end else if (reached) begin
                    state     <= IDLE;
                    deb_cnt   <= '0;
                    fsm_level <= 1'b1;
                end else begin
                    deb_cnt <= deb_next[CNT_WIDTH-1:0];
                end
                default: begin
                    state     <= IDLE;
                    deb_cnt   <= '0;
                    fsm_level <= 1'b1;
                end
            endcase
        end
    end

    // force_lo overrides the debounced level without disturbing the FSM.
    assign int_out = fsm_level & ~force_lo;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            thresh   <= CNT_WIDTH'(DEFAULT_THRESH);
            enable   <= 1'b1;
            force_lo <= 1'b0;
        end else if (wr) begin
            if (address == 2'd0) thresh <= writedata[CNT_WIDTH-1:0];
            if (address == 2'd3) begin
                enable   <= writedata[0];
                force_lo <= writedata[1];
            end
        end
    end

    // A clear that lands on a qualifying cycle keeps that event.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            event_cnt <= '0;
        else if (wr && (address == 2'd2))
            event_cnt <= qualify ? CNT_WIDTH'(1) : '0;
        else if (qualify && (event_cnt != '1))
            event_cnt <= event_cnt + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            readdata <= '0;
        end else begin
            case (address)
                2'd0:    readdata <= 32'(thresh);
                2'd1:    readdata <= {28'd0, state, sync, int_out};
                2'd2:    readdata <= 32'(event_cnt);
                default: readdata <= {30'd0, force_lo, enable};
            endcase
        end
    end

endmodule

// File: tb/tb_amax10_qsys_sensor_int_filter.sv
// Scoreboard bench: directed stimulus pushes expectations, a negedge monitor pops and compares.
module tb_amax10_qsys_sensor_int_filter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  address = 2'd0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic        sensor_int_n = 1'b1;
    logic        int_out;

    // Narrow-counter instance so saturation is reachable in a short run.
    logic [1:0]  s_address = 2'd0;
    logic        s_chipselect = 1'b0;
    logic        s_write_n = 1'b1;
    logic [31:0] s_writedata = '0;
    logic [31:0] s_readdata;
    logic        s_pin = 1'b1;
    logic        s_int_out;

    always #5 clk = ~clk;

    amax10_qsys_sensor_int_filter dut (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata),
        .sensor_int_n(sensor_int_n), .int_out(int_out)
    );

    amax10_qsys_sensor_int_filter #(.CNT_WIDTH(4), .DEFAULT_THRESH(1), .SYNC_STAGES(2)) u_sat (
        .clk(clk), .reset(reset), .address(s_address), .chipselect(s_chipselect),
        .write_n(s_write_n), .writedata(s_writedata), .readdata(s_readdata),
        .sensor_int_n(s_pin), .int_out(s_int_out)
    );

    typedef struct {
        int          kind;   // 0 int_out, 1 dut readdata, 2 u_sat readdata
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;
    logic rd_req = 1'b0;
    logic rd_vld = 1'b0;
    logic chk_int = 1'b0;
    logic done = 1'b0;
    logic drained = 1'b0;

    always @(posedge clk) rd_vld <= rd_req;

    always @(negedge clk) begin
        exp_t        e;
        logic [31:0] act;
        if (rd_vld) begin
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL readdata: got %0h, nothing expected", readdata);
            end else begin
                e   = sb.pop_front();
                act = (e.kind == 2) ? s_readdata : readdata;
                if (e.kind == 0 || act !== e.exp) begin
                    miscompares++;
                    $display("FAIL %s: got %0h expected %0h", e.name, act, e.exp);
                end
            end
        end
        if (chk_int) begin
            vectors++;
            act = {31'd0, int_out};
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL int_out: got %0h, nothing expected", act);
            end else begin
                e = sb.pop_front();
                if (e.kind != 0 || act !== e.exp) begin
                    miscompares++;
                    $display("FAIL %s: got %0h expected %0h", e.name, act, e.exp);
                end
            end
        end
        if (done && !drained) begin
            drained <= 1'b1;
            if (sb.size() != 0) begin
                miscompares++;
                $display("FAIL drain: got %0d pending entries expected 0", sb.size());
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input int which, input logic [1:0] a, input logic [31:0] d);
        if (which == 0) begin
            address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        end else begin
            s_address = a; s_writedata = d; s_chipselect = 1'b1; s_write_n = 1'b0;
        end
        tick(1);
        chipselect = 1'b0; write_n = 1'b1;
        s_chipselect = 1'b0; s_write_n = 1'b1;
    endtask

    task automatic rd(input int which, input logic [1:0] a, input logic [31:0] e, input string nm);
        if (which == 0) address = a;
        else            s_address = a;
        sb.push_back('{kind: which + 1, exp: e, name: nm});
        rd_req = 1'b1;
        tick(1);
        rd_req = 1'b0;
    endtask

    task automatic chk(input logic e, input string nm);
        sb.push_back('{kind: 0, exp: {31'd0, e}, name: nm});
        chk_int = 1'b1;
        tick(1);
        chk_int = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // reset state
        chk(1'b1, "rst_int_out");
        rd(0, 2'd0, 32'd500, "rst_thresh");
        rd(0, 2'd3, 32'd1, "rst_control");
        rd(0, 2'd1, 32'd3, "rst_status");
        rd(0, 2'd2, 32'd0, "rst_events");

        // N=4: pin edge to int_out edge is 6 clk
        wr(0, 2'd0, 32'd4);
        sensor_int_n = 1'b0;
        tick(5);
        chk(1'b1, "lat_clk5");
        chk(1'b0, "lat_clk6");
        rd(0, 2'd2, 32'd1, "events_first");
        rd(0, 2'd1, 32'd8, "status_asserted");

        // 3-clk high glitch while asserted
        sensor_int_n = 1'b1;
        tick(3);
        sensor_int_n = 1'b0;
        for (int i = 0; i < 6; i++) chk(1'b0, "hi_glitch");
        rd(0, 2'd2, 32'd1, "events_hi_glitch");

        sensor_int_n = 1'b1;
        tick(8);
        chk(1'b1, "deassert");
        wr(0, 2'd2, 32'hDEAD);
        rd(0, 2'd2, 32'd0, "events_cleared");

        // 3-clk low glitch while idle
        sensor_int_n = 1'b0;
        tick(3);
        sensor_int_n = 1'b1;
        for (int i = 0; i < 6; i++) chk(1'b1, "lo_glitch");
        rd(0, 2'd2, 32'd0, "events_lo_glitch");

        // THRESH=0 behaves as N=1
        wr(0, 2'd0, 32'd0);
        sensor_int_n = 1'b0;
        tick(2);
        chk(1'b1, "n0_clk2");
        chk(1'b0, "n0_clk3");
        rd(0, 2'd0, 32'd0, "thresh_zero");
        rd(0, 2'd2, 32'd1, "events_n0");
        sensor_int_n = 1'b1;
        tick(4);

        // clear on the same cycle as a qualify keeps the new event
        sensor_int_n = 1'b0;
        tick(2);
        wr(0, 2'd2, 32'd0);
        rd(0, 2'd2, 32'd1, "clear_on_qualify");
        sensor_int_n = 1'b1;
        tick(4);

        // saturation on the narrow instance
        for (int i = 0; i < 15; i++) begin
            s_pin = 1'b0; tick(3);
            s_pin = 1'b1; tick(3);
        end
        rd(1, 2'd2, 32'hF, "sat_15");
        for (int i = 0; i < 2; i++) begin
            s_pin = 1'b0; tick(3);
            s_pin = 1'b1; tick(3);
        end
        rd(1, 2'd2, 32'hF, "sat_hold");
        wr(1, 2'd2, 32'd0);
        rd(1, 2'd2, 32'd0, "sat_clear");

        // enable / force
        wr(0, 2'd0, 32'd4);
        sensor_int_n = 1'b0;
        tick(8);
        chk(1'b0, "ctl_asserted");
        wr(0, 2'd3, 32'd0);
        tick(1);
        chk(1'b1, "disable");
        rd(0, 2'd2, 32'd2, "events_disable");
        rd(0, 2'd1, 32'd1, "status_disabled");
        wr(0, 2'd3, 32'd1);
        tick(3);
        chk(1'b1, "reenable_clk3");
        chk(1'b0, "reenable_clk4");
        sensor_int_n = 1'b1;
        tick(8);
        chk(1'b1, "pre_force");
        wr(0, 2'd3, 32'd3);
        chk(1'b0, "force_on");
        chk(1'b0, "force_hold");
        rd(0, 2'd2, 32'd3, "events_force");
        wr(0, 2'd3, 32'd1);
        chk(1'b1, "force_off");

        // reset in QUAL_LO, pin held low through release
        wr(0, 2'd0, 32'd20);
        sensor_int_n = 1'b0;
        tick(6);
        rd(0, 2'd1, 32'd5, "status_qual_lo");
        tick(1);
        reset = 1'b1;
        chk(1'b1, "reset_int_out");
        tick(1);
        reset = 1'b0;
        rd(0, 2'd1, 32'd3, "status_after_rst");
        rd(0, 2'd0, 32'd500, "thresh_after_rst");
        tick(499);
        chk(1'b1, "requal_clk501");
        chk(1'b0, "requal_clk502");
        rd(0, 2'd2, 32'd1, "events_requal");

        tick(3);
        done = 1'b1;
        @(negedge clk);
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
